// File: rtl/iobus_pkg.sv
// iobus_pkg: shared types and field helpers for the host-bus framer.
//   state_t          framer states (IDLE / SHIFT / ACCESS)
//   ERR/TMO/OVR      status bit offsets, counted down from the response MSB
//   writePos/addrLsb command-word field positions
//   statusPos        absolute position of a status bit in a response word
package iobus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Status flags sit in the top three bits of the response word.
    localparam int ERR = 1;
    localparam int TMO = 2;
    localparam int OVR = 3;

    function automatic int statusPos(input int wordW, input int ofs);
        return wordW - ofs;
    endfunction

    function automatic int writePos(input int wordW);
        return wordW - 1;
    endfunction

    function automatic int addrLsb(input int dataW);
        return dataW;
    endfunction

endpackage

// File: rtl/iobus_slot_decoder.sv
// iobus_slot_decoder: maps a peripheral address to its slot page.
//   addr        in   ADDR_W   peripheral address
//   slotOneHot  out  N_SLOTS  one-hot slot select, all zero when unmapped
//   slotIdx     out  SLOT_W   binary slot index (low bits of the page)
//   mapped      out  1        page number is below N_SLOTS
// Purely combinational.
module iobus_slot_decoder
    import iobus_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int SLOT_SHIFT = 8,
    parameter int N_SLOTS    = 4,
    parameter int SLOT_W     = 2
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [N_SLOTS-1:0] slotOneHot,
    output logic [SLOT_W-1:0]  slotIdx,
    output logic               mapped
);

    logic [ADDR_W-1:0] page;

    always_comb begin
        page       = addr >> SLOT_SHIFT;
        mapped     = (page < ADDR_W'(N_SLOTS));
        slotIdx    = page[SLOT_W-1:0];
        slotOneHot = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            slotOneHot[s] = mapped && (page == ADDR_W'(s));
        end
    end

endmodule

// File: rtl/iobus_framer.sv
// iobus_framer: byte-serial host-bus front end for the peripheral pages.
// Assembles a command word from LANE_W-bit beats, decodes its address to a
// slot, runs a req/ack access with timeout and serialises the result of that
// access on MISO during the following frame.
//   iClk, iRst    clock, synchronous active-high reset
//   iSelect       beat strobe; iBusMOSI beat data, lane 0 first
//   oBusMISO      response lane for the beat being presented
//   oBusy         high while an access is in progress
//   oFrameAbort   one-cycle pulse after a frame is cut short
//   oAddr/oWData/oWrite  latched command fields
//   oReq/iAck     one-hot request / per-slot acknowledge
//   iRData        per-slot read data, slot s at [s*DATA_W +: DATA_W]
module iobus_framer
    import iobus_pkg::*;
#(
    parameter int LANE_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int SLOT_SHIFT = 8,
    parameter int N_SLOTS    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iSelect,
    input  logic [LANE_W-1:0]         iBusMOSI,
    output logic [LANE_W-1:0]         oBusMISO,
    output logic                      oBusy,
    output logic                      oFrameAbort,
    output logic [ADDR_W-1:0]         oAddr,
    output logic [DATA_W-1:0]         oWData,
    output logic                      oWrite,
    output logic [N_SLOTS-1:0]        oReq,
    input  logic [N_SLOTS-1:0]        iAck,
    input  logic [N_SLOTS*DATA_W-1:0] iRData
);

    localparam int WORD_W   = LANE_W * WORD_BYTES;
    localparam int CNT_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SLOT_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int WR_POS   = writePos(WORD_W);
    localparam int ADDR_LSB = addrLsb(DATA_W);
    localparam int ERR_POS  = statusPos(WORD_W, ERR);
    localparam int TMO_POS  = statusPos(WORD_W, TMO);
    localparam int OVR_POS  = statusPos(WORD_W, OVR);

    if (WORD_W != 1 + ADDR_W + DATA_W) begin : gWidthCheck
        $error("iobus_framer: LANE_W*WORD_BYTES must equal 1+ADDR_W+DATA_W");
    end

    state_t              state, stateNext;
    logic [CNT_W-1:0]    cnt, cntNext;
    logic [TO_W-1:0]     toCnt;
    logic [WORD_W-1:0]   shiftReg, assembled, resp, respNext;
    logic [ADDR_W-1:0]   addrReg;
    logic [DATA_W-1:0]   wdataReg, rdSel;
    logic                writeReg, ovrSeen, abortReg;
    logic                beatTake, cmdLatch, abortNow;
    logic                lastBeat, ackHit, toLast, accessDone;
    logic [LANE_W-1:0]   misoLane;
    logic [N_SLOTS-1:0]  slotOneHot;
    logic [SLOT_W-1:0]   slotIdx;
    logic                mapped;

    iobus_slot_decoder #(
        .ADDR_W     (ADDR_W),
        .SLOT_SHIFT (SLOT_SHIFT),
        .N_SLOTS    (N_SLOTS),
        .SLOT_W     (SLOT_W)
    ) uDecoder (
        .addr       (addrReg),
        .slotOneHot (slotOneHot),
        .slotIdx    (slotIdx),
        .mapped     (mapped)
    );

    // Beat insertion, MISO lane pick and read-data mux, all indexed by
    // small counters so they are written as explicit compare-and-select.
    always_comb begin
        assembled = shiftReg;
        misoLane  = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (cnt == CNT_W'(i)) begin
                assembled[i*LANE_W +: LANE_W] = iBusMOSI;
                misoLane = resp[i*LANE_W +: LANE_W];
            end
        end
        rdSel = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (slotIdx == SLOT_W'(s)) begin
                rdSel = iRData[s*DATA_W +: DATA_W];
            end
        end
    end

    assign lastBeat   = (cnt == CNT_W'(WORD_BYTES - 1));
    assign ackHit     = |(iAck & slotOneHot);
    assign toLast     = (toCnt == TO_W'(TIMEOUT - 1));
    // Unmapped pages finish on their first cycle; an ack on the final
    // timeout cycle still counts as a normal completion.
    assign accessDone = !mapped || ackHit || toLast;

    always_comb begin
        respNext          = '0;
        respNext[OVR_POS] = ovrSeen | iSelect;
        if (!mapped) begin
            respNext[ERR_POS]      = 1'b1;
            respNext[DATA_W-1:0]   = '1;
        end else if (ackHit) begin
            respNext[DATA_W-1:0]   = writeReg ? '0 : rdSel;
        end else begin
            respNext[ERR_POS]      = 1'b1;
            respNext[TMO_POS]      = 1'b1;
        end
    end

    // Next-state logic. IDLE and SHIFT share the beat path because cnt is
    // always 0 in IDLE, which also covers single-beat frames.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        beatTake  = 1'b0;
        cmdLatch  = 1'b0;
        abortNow  = 1'b0;
        case (state)
            IDLE, SHIFT: begin
                if (iSelect) begin
                    beatTake = 1'b1;
                    if (lastBeat) begin
                        cmdLatch  = 1'b1;
                        stateNext = ACCESS;
                        cntNext   = '0;
                    end else begin
                        stateNext = SHIFT;
                        cntNext   = cnt + 1'b1;
                    end
                end else if (state == SHIFT) begin
                    abortNow  = 1'b1;
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            end
            ACCESS: begin
                if (accessDone) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= IDLE;
            cnt      <= '0;
            toCnt    <= '0;
            shiftReg <= '0;
            resp     <= '0;
            addrReg  <= '0;
            wdataReg <= '0;
            writeReg <= 1'b0;
            ovrSeen  <= 1'b0;
            abortReg <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            abortReg <= abortNow;
            if (beatTake) begin
                shiftReg <= assembled;
            end
            if (cmdLatch) begin
                writeReg <= assembled[WR_POS];
                addrReg  <= assembled[WR_POS-1:ADDR_LSB];
                wdataReg <= assembled[DATA_W-1:0];
                toCnt    <= '0;
                ovrSeen  <= 1'b0;
            end else if (state == ACCESS) begin
                toCnt   <= toCnt + 1'b1;
                ovrSeen <= ovrSeen | iSelect;
                if (accessDone) begin
                    resp <= respNext;
                end
            end
        end
    end

    assign oBusMISO    = misoLane;
    assign oBusy       = (state == ACCESS);
    assign oFrameAbort = abortReg;
    assign oAddr       = addrReg;
    assign oWData      = wdataReg;
    assign oWrite      = writeReg;
    assign oReq        = (state == ACCESS) ? slotOneHot : '0;

endmodule

// File: tb/tb_iobus_framer.sv
module tb_iobus_framer;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iSelect;
    logic [7:0]  iBusMOSI;
    logic [7:0]  oBusMISO;
    logic        oBusy;
    logic        oFrameAbort;
    logic [14:0] oAddr;
    logic [15:0] oWData;
    logic        oWrite;
    logic [3:0]  oReq;
    logic [3:0]  iAck;
    logic [63:0] iRData;

    int total = 0;
    int bad   = 0;

    always #5 iClk = ~iClk;

    iobus_framer dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iSelect     (iSelect),
        .iBusMOSI    (iBusMOSI),
        .oBusMISO    (oBusMISO),
        .oBusy       (oBusy),
        .oFrameAbort (oFrameAbort),
        .oAddr       (oAddr),
        .oWData      (oWData),
        .oWrite      (oWrite),
        .oReq        (oReq),
        .iAck        (iAck),
        .iRData      (iRData)
    );

    typedef struct {
        logic [31:0] word;
        int          ackAt;
        logic [15:0] rd;
        int          sel;
        logic [31:0] expResp;
        int          expDur;
        logic [3:0]  expReq;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference: what the peripheral access should produce, from the rules
    // (page lookup, ack index vs. the 64-cycle limit, overrun if the host
    // strobed at any time during the access).
    function automatic void model(input logic [31:0] word, input int ackAt,
                                  input logic [15:0] rd, input int sel,
                                  output logic [31:0] resp, output int dur,
                                  output logic [3:0] req);
        int page;
        page = int'(word[30:16]) / 256;
        if (page >= 4) begin
            resp = 32'h8000_FFFF;
            dur  = 1;
            req  = 4'b0;
        end else begin
            req = 4'(1 << page);
            if (ackAt >= 0 && ackAt < 64) begin
                dur  = ackAt + 1;
                resp = word[31] ? 32'h0 : {16'h0, rd};
            end else begin
                dur  = 64;
                resp = 32'hC000_0000;
            end
        end
        if (sel > 0) resp = resp | 32'h2000_0000;
    endfunction

    task automatic runFrame(input logic [31:0] word, input int ackAt,
                            input logic [15:0] rd, input int sel,
                            output logic [31:0] miso, output int dur,
                            output int reqCyc, output logic [3:0] reqSeen,
                            output logic [31:0] cmdSeen);
        int page;
        logic [3:0] tgt;
        page    = int'(word[30:16]) / 256;
        tgt     = (page < 4) ? 4'(1 << page) : 4'b0;
        miso    = '0;
        dur     = 0;
        reqCyc  = 0;
        reqSeen = '0;
        cmdSeen = '0;
        for (int b = 0; b < 4; b++) begin
            @(negedge iClk);
            miso[b*8 +: 8] = oBusMISO;
            iSelect  = 1'b1;
            iBusMOSI = word[b*8 +: 8];
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge iClk);
            if (!oBusy) break;
            if (c == 0) cmdSeen = {oWrite, oAddr, oWData};
            dur++;
            if (oReq != 4'b0) reqCyc++;
            reqSeen  = reqSeen | oReq;
            iSelect  = (c < sel);
            iBusMOSI = 8'($urandom);
            iAck     = 4'($urandom) & ~tgt;
            if (c == ackAt) iAck = iAck | tgt;
            iRData   = {$urandom, $urandom};
            if (page < 4) iRData[page*16 +: 16] = rd;
        end
        iSelect = 1'b0;
        iAck    = 4'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] miso, cmdSeen, prevExp, word, expResp;
        logic [3:0]  reqSeen, expReq;
        int          dur, reqCyc, expDur, ackAt, sel, r;
        logic [7:0]  lane0, lane1;

        //             word          ack  rd        sel expResp       dur req
        tbl[0] = '{32'h8105_1234,  2, 16'h7777, 0, 32'h0000_0000,  3, 4'b0010};
        tbl[1] = '{32'h0310_0000,  0, 16'hBEEF, 0, 32'h0000_BEEF,  1, 4'b1000};
        tbl[2] = '{32'h0400_0000,  0, 16'h0000, 0, 32'h8000_FFFF,  1, 4'b0000};
        tbl[3] = '{32'h0110_0000, -1, 16'h0000, 0, 32'hC000_0000, 64, 4'b0010};
        tbl[4] = '{32'h0205_0000,  4, 16'h5A5A, 5, 32'h2000_5A5A,  5, 4'b0100};
        tbl[5] = '{32'h00FF_0000, 63, 16'h1111, 0, 32'h0000_1111, 64, 4'b0001};
        tbl[6] = '{32'h83FF_ABCD,  1, 16'h4444, 0, 32'h0000_0000,  2, 4'b1000};
        tbl[7] = '{32'h7FFF_0000,  0, 16'h0000, 1, 32'hA000_FFFF,  1, 4'b0000};
        tbl[8] = '{32'h8400_1234,  0, 16'h0000, 0, 32'h8000_FFFF,  1, 4'b0000};
        tbl[9] = '{32'h0100_0000, -1, 16'h0000, 2, 32'hE000_0000, 64, 4'b0010};

        iRst = 1'b1; iSelect = 1'b0; iBusMOSI = '0; iAck = '0; iRData = '0;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
        chk("rst_req",   64'(oReq), 64'h0);
        chk("rst_busy",  64'(oBusy), 64'h0);
        chk("rst_miso",  64'(oBusMISO), 64'h0);
        chk("rst_abort", 64'(oFrameAbort), 64'h0);
        chk("rst_cmd",   64'({oWrite, oAddr, oWData}), 64'h0);

        prevExp = 32'h0;
        for (int i = 0; i < 10; i++) begin
            runFrame(tbl[i].word, tbl[i].ackAt, tbl[i].rd, tbl[i].sel,
                     miso, dur, reqCyc, reqSeen, cmdSeen);
            chk($sformatf("tbl%0d_miso", i), 64'(miso), 64'(prevExp));
            chk($sformatf("tbl%0d_dur", i), 64'(dur), 64'(tbl[i].expDur));
            chk($sformatf("tbl%0d_req", i), 64'(reqSeen), 64'(tbl[i].expReq));
            chk($sformatf("tbl%0d_reqcyc", i), 64'(reqCyc),
                64'((tbl[i].expReq != 4'b0) ? tbl[i].expDur : 0));
            chk($sformatf("tbl%0d_cmd", i), 64'(cmdSeen), 64'(tbl[i].word));
            prevExp = tbl[i].expResp;
        end

        // Frame cut short after two beats.
        @(negedge iClk);
        lane0 = oBusMISO; iSelect = 1'b1; iBusMOSI = 8'h11;
        @(negedge iClk);
        lane1 = oBusMISO; iBusMOSI = 8'h22;
        @(negedge iClk);
        iSelect = 1'b0;
        chk("abort_pre", 64'(oFrameAbort), 64'h0);
        @(negedge iClk);
        chk("abort_pulse", 64'(oFrameAbort), 64'h1);
        chk("abort_busy", 64'(oBusy), 64'h0);
        chk("abort_req", 64'(oReq), 64'h0);
        @(negedge iClk);
        chk("abort_end", 64'(oFrameAbort), 64'h0);
        chk("abort_lanes", 64'({lane1, lane0}), 64'(prevExp[15:0]));

        // Randomized frames against the reference model.
        for (int n = 0; n < 40; n++) begin
            word = {1'($urandom), 15'($urandom_range(0, 16'h05FF)), 16'($urandom)};
            r = $urandom_range(0, 9);
            ackAt = (r == 0) ? -1 : (r == 1) ? 63 : int'($urandom_range(0, 6));
            sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            model(word, ackAt, 16'h9C3A ^ 16'(n * 7), sel, expResp, expDur, expReq);
            runFrame(word, ackAt, 16'h9C3A ^ 16'(n * 7), sel,
                     miso, dur, reqCyc, reqSeen, cmdSeen);
            chk($sformatf("rnd%0d_miso", n), 64'(miso), 64'(prevExp));
            chk($sformatf("rnd%0d_dur", n), 64'(dur), 64'(expDur));
            chk($sformatf("rnd%0d_req", n), 64'(reqSeen), 64'(expReq));
            chk($sformatf("rnd%0d_reqcyc", n), 64'(reqCyc),
                64'((expReq != 4'b0) ? expDur : 0));
            prevExp = expResp;
        end

        // Reset during an access that would otherwise time out.
        word = 32'h0110_0000;
        for (int b = 0; b < 4; b++) begin
            @(negedge iClk);
            iSelect = 1'b1; iBusMOSI = word[b*8 +: 8];
        end
        @(negedge iClk);
        iSelect = 1'b0;
        chk("mid_req", 64'(oReq), 64'h2);
        chk("mid_busy", 64'(oBusy), 64'h1);
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        chk("rst2_req", 64'(oReq), 64'h0);
        chk("rst2_busy", 64'(oBusy), 64'h0);
        chk("rst2_miso", 64'(oBusMISO), 64'h0);
        runFrame(32'h0310_0000, 1, 16'hCAFE, 0, miso, dur, reqCyc, reqSeen, cmdSeen);
        chk("post_miso", 64'(miso), 64'h0);
        chk("post_dur", 64'(dur), 64'd2);
        chk("post_req", 64'(reqSeen), 64'h8);
        runFrame(32'h8105_1234, 0, 16'h0, 0, miso, dur, reqCyc, reqSeen, cmdSeen);
        chk("post_rd", 64'(miso), 64'h0000_CAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
